// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add unsigned multiplier.
//
// Retires one multiplier bit per cycle. An accepted a*b pair spends exactly WIDTH cycles in
// RUN, whatever the operand values, and then waits in DONE until the consumer takes the
// product. Input and output transfers never overlap.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   operands on a/b are valid
//   in_ready   block can accept operands (high only in IDLE, decoded from state)
//   a          multiplicand, unsigned, WIDTH bits
//   b          multiplier, unsigned, WIDTH bits
//   out_valid  p holds a finished product (registered, high only in DONE)
//   out_ready  consumer takes p
//   p          exact product a*b, 2*WIDTH bits; held until the next product completes

module seq_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t state_q, state_d;

    // The multiplicand register is product-wide because it moves left one position per step.
    // After WIDTH-1 shifts its top set bit sits at position 2*WIDTH-2, so nothing is lost.
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    p_q, p_d;

    logic          accept;
    logic          last_bit;
    logic [PW-1:0] partial;
    logic [PW-1:0] acc_sum;

    assign accept   = (state_q == StIdle) && in_valid;
    assign last_bit = (cnt_q == LastBit);

    // mplier_q[0] is always the multiplier bit for the current counter position.
    assign partial  = mplier_q[0] ? mcand_q : '0;
    // The sum of all partial products is at most (2^W-1)^2, which fits in 2*W bits.
    assign acc_sum  = acc_q + partial;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // in_valid is ignored here; a new operand pair can only be taken in IDLE.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from state only
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle:  in_ready  = 1'b1;
            StRun:   ;
            StDone:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;

        if (accept) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == StRun) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // The final step's sum goes to p directly, so p is valid together with DONE.
            if (last_bit) begin
                p_d = acc_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    logic clk;
    logic rst;

    // WIDTH=16 instance
    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        out_valid16;
    logic        out_ready16;
    logic [31:0] p16;

    // WIDTH=8 instance
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] p8;

    int vectors;
    int miscompares;

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .p         (p16)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .p         (p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation on the 16-bit instance. Inputs change on the falling edge, outputs
    // are sampled on the falling edge. hold = cycles of out_ready=0 once out_valid is seen;
    // scramble keeps in_valid high with random operands throughout RUN and DONE.
    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input int hold,
                         input bit scramble);
        int          n;
        logic [31:0] exp;
        logic [31:0] r;
        exp = 32'(av) * 32'(bv);

        n = 0;
        while (!in_ready16 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("w16_ready_before_start", 32'(in_ready16), 32'd1);

        a16 = av;
        b16 = bv;
        in_valid16  = 1'b1;
        out_ready16 = (hold == 0);
        @(negedge clk);
        check("w16_ready_low_after_accept", 32'(in_ready16), 32'd0);
        if (!scramble) in_valid16 = 1'b0;

        n = 0;
        while (!out_valid16 && n < 40) begin
            if (scramble) begin
                r = $urandom;
                a16 = r[15:0];
                b16 = r[31:16];
            end
            @(negedge clk);
            n++;
        end
        check("w16_latency", 32'(n), 32'd16);
        check("w16_product", p16, exp);

        for (int i = 0; i < hold; i++) begin
            if (scramble) begin
                r = $urandom;
                a16 = r[15:0];
                b16 = r[31:16];
            end
            @(negedge clk);
            check("w16_hold_valid", 32'(out_valid16), 32'd1);
            check("w16_hold_p", p16, exp);
            check("w16_hold_ready_low", 32'(in_ready16), 32'd0);
        end

        out_ready16 = 1'b1;
        @(negedge clk);
        check("w16_valid_drop", 32'(out_valid16), 32'd0);
        check("w16_ready_back", 32'(in_ready16), 32'd1);
        check("w16_p_retained", p16, exp);
        in_valid16 = 1'b0;
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv);
        int          n;
        logic [31:0] exp;
        exp = 32'(av) * 32'(bv);

        n = 0;
        while (!in_ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        a8 = av;
        b8 = bv;
        in_valid8  = 1'b1;
        out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("w8_latency", 32'(n), 32'd8);
        check("w8_product", 32'(p8), exp);
        @(negedge clk);
        check("w8_valid_drop", 32'(out_valid8), 32'd0);
        check("w8_ready_back", 32'(in_ready8), 32'd1);
    endtask

    initial begin
        int          n;
        logic        seen;
        logic [31:0] r;
        logic [31:0] s;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        in_valid16  = 1'b0;
        out_ready16 = 1'b0;
        a16         = '0;
        b16         = '0;
        in_valid8   = 1'b0;
        out_ready8  = 1'b0;
        a8          = '0;
        b8          = '0;

        // Reset held for 3 cycles under random inputs
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            a16 = r[15:0];
            b16 = r[31:16];
            in_valid16  = r[0];
            out_ready16 = r[1];
            @(negedge clk);
            check("rst_in_ready", 32'(in_ready16), 32'd1);
            check("rst_out_valid", 32'(out_valid16), 32'd0);
            check("rst_p", p16, 32'd0);
        end
        in_valid16  = 1'b0;
        out_ready16 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(in_ready16), 32'd1);
        check("post_rst_no_valid", 32'(out_valid16), 32'd0);

        // Directed cases
        run16(16'd3, 16'd5, 0, 1'b0);
        run16(16'hFFFF, 16'hFFFF, 0, 1'b0);
        run16(16'h0000, 16'hABCD, 0, 1'b0);
        run16(16'h1234, 16'h0010, 5, 1'b1);

        // Mid-operation reset: p is nonzero from the previous product before the abort
        a16 = 16'h00FF;
        b16 = 16'h0101;
        in_valid16  = 1'b1;
        out_ready16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_p_before_rst", p16, 32'h0001_2340);
        rst = 1'b0;
        #1;
        check("abort_p_async_clear", p16, 32'd0);
        check("abort_ready_async", 32'(in_ready16), 32'd1);
        check("abort_valid_async", 32'(out_valid16), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            seen = seen | out_valid16;
        end
        check("abort_no_output", 32'(seen), 32'd0);
        run16(16'd2, 16'd3, 0, 1'b0);

        // Random operations, random back-pressure and input scrambling
        for (int i = 0; i < 12; i++) begin
            r = $urandom;
            s = $urandom;
            run16(r[15:0], r[31:16], int'(s[1:0]), s[2]);
        end

        // 8-bit instance
        run8(8'd200, 8'd255);
        run8(8'hFF, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            r = $urandom;
            run8(r[7:0], r[15:8]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative radix-2 shift-add unsigned multiplier with valid/ready handshakes on both sides. It is the inverse-direction companion of the pipelined `divider` stages: a quotient/divisor pair is fed back through it to reconstruct the dividend, both for self-check and for the next datapath stage. It processes one multiplier bit per cycle at a fixed latency, so the resulting area is much smaller than a combinational multiplier.

## Interface
- `WIDTH`, default 16: operand width; product is 2*WIDTH bits; legal values ≥ 2.
- `clk` input, 1: sole clock, rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: operands on `a`/`b` are valid.
- `in_ready` output, 1: block can accept operands.
- `a` input, WIDTH: multiplicand, unsigned.
- `b` input, WIDTH: multiplier, unsigned.
- `out_valid` output, 1: `p` holds a finished product.
- `out_ready` input, 1: consumer takes `p`.
- `p` output, 2*WIDTH: product a*b, unsigned, exact.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: bit-serial accumulate.
  - DONE: `out_valid`=1.
- IDLE→RUN on the edge where `in_valid && in_ready`:
  - `a` and `b` are captured into internal registers.
  - Accumulator is cleared.
  - Bit counter is cleared to 0.
- RUN, each edge:
  - If the current multiplier bit is 1, add the multiplicand aligned to the counter position into the 2*WIDTH accumulator.
  - Then advance: either shift the multiplier right and multiplicand left, or use the P-register shift-right form.
  - Counter increments.
- RUN→DONE on the edge that processes bit WIDTH-1, i.e. counter == WIDTH-1. The accumulator is copied to `p` on that edge.
- DONE→IDLE on the edge where `out_valid && out_ready`.
- Arithmetic:
  - Accumulator is 2*WIDTH bits wide. Add carries are never lost.
  - `p` equals the exact `a*b` for all inputs, including max×max.
- Operand isolation:
  - `a`, `b` and `in_valid` are ignored outside IDLE.
  - Input changes during RUN/DONE must not affect the result.
- No early termination. Latency is independent of operand values, including zero operands.
- `in_ready` is combinational from state only (IDLE). It never depends on `in_valid`.
- `out_valid` is registered state (DONE).
- Reset (`rst`=0), asserted at any time including mid-RUN or in DONE:
  - Asynchronously forces IDLE.
  - Clears `p`, the accumulator, the operand registers and the counter.
  - The in-flight operation is discarded with no output.

## Timing
- Reset values:
  - `in_ready`=1.
  - `out_valid`=0.
  - `p`=0.
- Latency:
  - Acceptance edge E0.
  - RUN edges E1..E(WIDTH-1) and the final RUN edge EWIDTH.
  - `out_valid` becomes 1 after edge EWIDTH, i.e. WIDTH cycles after acceptance (16 cycles for the default).
- `in_ready` falls after E0 and stays 0 through RUN and DONE.
- Hand-off:
  - `p` and `out_valid` are stable while `out_valid`=1 and `out_ready`=0, for any number of cycles.
  - `out_ready` may be high before `out_valid`. The handshake then completes on the first DONE cycle.
- After the output handshake edge:
  - `out_valid`=0 and `in_ready`=1 in the next cycle.
  - `p` retains its last value until the next RUN→DONE transition.
- Throughput: one operation per WIDTH+2 cycles minimum, with back-to-back handshakes (accept, WIDTH RUN cycles, 1 DONE cycle). No input/output overlap.
- Simultaneous `in_valid` and `out_ready` in DONE: only the output handshake occurs. The input is accepted no earlier than the following IDLE cycle.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random inputs → `in_ready`=1, `out_valid`=0, `p`=0x00000000. Release → still IDLE.
- Basic latency, WIDTH=16:
  - Stimulus: `a`=3, `b`=5, `in_valid` pulsed for 1 cycle, `out_ready`=1.
  - Required: `out_valid` rises exactly 16 cycles after acceptance with `p`=0x0000000F, for 1 cycle. `in_ready`=1 on the next cycle.
- Full-scale carry: `a`=0xFFFF, `b`=0xFFFF → `p`=0xFFFE0001.
- Zero operands: 0x0000×0xABCD → `p`=0, with the same 16-cycle latency.
- Back-pressure and isolation:
  - Stimulus: 0x1234×0x0010 with `out_ready`=0 for 5 cycles after `out_valid`. During RUN, `a`/`b` change randomly and `in_valid`=1 is held.
  - Required: `p`=0x00012340 held stable for all 5 cycles. No second operation is accepted until after the output handshake.
- Mid-operation reset:
  - Stimulus: start 0x00FF×0x0101, then assert `rst` 7 cycles after acceptance. Release, then issue 0x0002×0x0003.
  - Required: no `out_valid` for the aborted operation. `p`=0 immediately on reset. The second result is `p`=6 after 16 cycles.
- WIDTH=8 instance: 200×255 → `p`=0xC738 (51000) after 8 cycles.
